ev_pedal_conditioner: RTL and testbench
=======================================

# ev_pedal_conditioner

Upstream conditioning stage for the EV motor controller's accelerator/brake command path. Samples the raw 4-bit pedal sensors on a divided tick and applies slew limiting to the accelerator. Enforces brake-over-throttle override and detects a shorted-sensor fault. Presents clean 4-bit accelerator/brake values, with an update strobe, to the motor-speed stage.

## Interface
Parameters:
- `SAMPLE_DIV`, 16: clocks per sample tick; legal range 2..65535.
- `RAMP_STEP`, 1: maximum accelerator increase per tick; legal range 1..15.
- `FAULT_LIMIT`, 3: consecutive shorted-sensor ticks before FAULT; legal range 1..15.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. Synchronous and active-high.
- `ena` input 1: when low, all state is frozen, including the counter.
- `power_on` input 1: system power request (PLC OR HMI, combined upstream).
- `accel_raw` input 4: raw accelerator pedal sensor.
- `brake_raw` input 4: raw brake pedal sensor.
- `accel_out` output 4: conditioned accelerator value.
- `brake_out` output 4: conditioned brake value.
- `cmd_valid` output 1: one-cycle pulse marking an output update.
- `state` output 2: 0 = IDLE, 1 = DRIVE, 2 = OVERRIDE, 3 = FAULT.
- `override` output 1: high while `state` is OVERRIDE.
- `fault` output 1: high while `state` is FAULT.

## Operation
- **Reset** (`rst` = 1 at a `clk` edge):
  - All outputs go to 0; `state` goes to IDLE.
  - Tick counter, fault counter and averaging buffer clear.
  - Reset has priority over `ena`.
- **Power-off.** `power_on` = 0 (with `ena` = 1) forces the same values as reset on every cycle. This is the only non-reset exit from FAULT.
- **Tick generation.**
  - The counter runs 0..SAMPLE_DIV-1 while `power_on` = 1.
  - A tick occurs on the cycle where counter == SAMPLE_DIV-1; the counter then wraps to 0.
- **Tick processing.** On each tick the block samples `accel_raw` and `brake_raw` and computes `target`. `target` is the averaged accelerator value when averaging is enabled, otherwise `accel_raw`.
- **FSM.** Evaluated on ticks only. Priority order: power-off > FAULT > OVERRIDE > DRIVE.
  - IDLE → DRIVE on the first tick with `power_on` = 1.
  - Fault counter:
    - Increments on a tick when `accel_raw` == 4'hF and `brake_raw` == 4'hF; otherwise it resets to 0.
    - Saturates at FAULT_LIMIT.
    - Reaching FAULT_LIMIT moves any state to FAULT on that same tick.
  - DRIVE → OVERRIDE when `brake_raw` >= 2 and `target` > 0.
  - OVERRIDE → DRIVE on a tick with `accel_raw` == 0. Brake release alone does not exit.
  - FAULT is sticky until power-off or reset.
- **Output rules per state:**
  - IDLE: `accel_out` = 0, `brake_out` = 0.
  - DRIVE: `brake_out` = `brake_raw`, unfiltered. `accel_out`:
    - if `target` > `accel_out`, it rises by min(RAMP_STEP, `target` - `accel_out`);
    - otherwise it takes `target` immediately (fast release).
  - OVERRIDE: `accel_out` = 0; `brake_out` = `brake_raw`.
  - FAULT: `accel_out` = 0; `brake_out` = 4'hF (full brake).
- **Arithmetic widths:**
  - Ramp arithmetic uses 5 bits and saturates at 15.
  - Averaging sum is 6 bits; the average is sum >> 2, truncated.

## Timing
- **Tick-to-output latency.** The sample is captured at the tick edge. `accel_out`, `brake_out`, `state`, `override` and `fault` change at that edge, and `cmd_valid` is high for the following cycle only.
- **Update rate.** `cmd_valid` pulses exactly once per SAMPLE_DIV cycles while powered and `ena` = 1.
- **Power-on.** The first update arrives SAMPLE_DIV cycles after `power_on` rises. That update takes IDLE → DRIVE and applies the DRIVE rules to its sample.
- **Freeze.** `ena` low for N cycles delays the next tick by exactly N cycles; `cmd_valid` is not raised while frozen.
- **Reset mid-operation.** Outputs are 0 on the cycle after `rst`; the ramp restarts from 0.
- **Simultaneous events.** When the shorted-sensor condition completes the fault count on the same tick as an override condition, FAULT wins.

## Configuration
- `PEDAL_AVG_EN` defined:
  - `target` is the 4-tap moving average of `accel_raw`, over the current sample and the previous three ticks.
  - The buffer clears on reset and on power-off.
- `PEDAL_AVG_EN` undefined: `target` = `accel_raw`, and no buffer registers are instantiated.
- Brake path and fault detection are identical in both builds.

## Test plan
All scenarios use SAMPLE_DIV=4, RAMP_STEP=1, FAULT_LIMIT=3.
- **Ramp, macro off.** `rst` pulse, then `power_on`=1, `accel_raw`=8, `brake_raw`=0 → `state`=DRIVE; `accel_out` steps 1,2,…,8 on successive updates; `cmd_valid` high every 4th cycle.
- **Fast release.** `accel_out`=8, then `accel_raw`=0 → next update `accel_out`=0.
- **Brake override.** `accel_raw`=6 steady, `brake_raw`=3 → next update: `accel_out`=0, `brake_out`=3, `override`=1. Then `brake_raw`=0 with `accel_raw`=6 → `accel_out` stays 0. Then `accel_raw`=0 for one tick → DRIVE; `accel_raw`=6 → ramp restarts 1,2,….
- **Shorted sensor.** `accel_raw`=`brake_raw`=F for 3 ticks → 3rd update: `fault`=1, `brake_out`=F, `accel_out`=0. Normal inputs afterwards leave FAULT held. `power_on`=0 → IDLE, `fault`=0.
- **Averaging, macro on.** Step `accel_raw` 0→8 → targets 2,4,6,8; `accel_out` 1,2,3,4,5,6,7,8.
- **Reset and freeze.** `rst` for 1 cycle mid-ramp at `accel_out`=5 → all outputs 0 next cycle. `ena`=0 for 3 cycles → next `cmd_valid` arrives 3 cycles late.

Source files
------------

// File: rtl/ev_pedal_conditioner.sv
// Pedal conditioner: tick-sampled accel/brake with ramp limit, brake override, shorted-sensor FAULT; PEDAL_AVG_EN adds 4-tap accel averaging.
// Outputs update at the tick edge, cmd_valid follows for one cycle; no backpressure, ena=0 freezes everything.
module ev_pedal_conditioner #(
  parameter int SAMPLE_DIV  = 16,
  parameter int RAMP_STEP   = 1,
  parameter int FAULT_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       power_on,
  input  logic [3:0] accel_raw,
  input  logic [3:0] brake_raw,
  output logic [3:0] accel_out,
  output logic [3:0] brake_out,
  output logic       cmd_valid,
  output logic [1:0] state,
  output logic       override,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    OVERRIDE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(SAMPLE_DIV - 1);
  localparam logic [4:0]  STEP5   = 5'(RAMP_STEP);
  localparam logic [3:0]  FLIM    = 4'(FAULT_LIMIT);

  state_t      st, st_nxt;
  logic [15:0] cnt;
  logic [3:0]  fcnt, fcnt_nxt;
  logic [3:0]  accel_nxt, brake_nxt, drive_accel, target;
  logic [4:0]  ramp_sum;
  logic        shorted, clr, tick;

  assign clr  = rst || (ena && !power_on);
  assign tick = ena && power_on && (cnt == CNT_MAX);

`ifdef PEDAL_AVG_EN
  logic [3:0] hist0, hist1, hist2;
  logic [5:0] avg_sum;
  assign avg_sum = {2'b00, accel_raw} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
  assign target  = avg_sum[5:2];
`else
  assign target = accel_raw;
`endif

  always_comb begin
    shorted  = (accel_raw == 4'hF) && (brake_raw == 4'hF);
    fcnt_nxt = 4'd0;
    if (shorted)
      fcnt_nxt = (fcnt >= FLIM) ? FLIM : fcnt + 4'd1;
    // 5-bit sum can exceed 15; clamping to target (<=15) also provides the saturation
    ramp_sum    = {1'b0, accel_out} + STEP5;
    drive_accel = target;
    if (target > accel_out)
      drive_accel = (ramp_sum > {1'b0, target}) ? target : ramp_sum[3:0];

    st_nxt    = st;
    accel_nxt = accel_out;
    brake_nxt = brake_out;
    if (fcnt_nxt == FLIM || st == FAULT) begin
      st_nxt    = FAULT;
      accel_nxt = 4'd0;
      brake_nxt = 4'hF;
    end else begin
      case (st)
        IDLE, DRIVE: begin
          if (st == DRIVE && brake_raw >= 4'd2 && target != 4'd0) begin
            st_nxt    = OVERRIDE;
            accel_nxt = 4'd0;
          end else begin
            st_nxt    = DRIVE;
            accel_nxt = drive_accel;
          end
          brake_nxt = brake_raw;
        end
        OVERRIDE: begin
          // only a released accelerator ends the override, not a released brake
          if (accel_raw == 4'd0) begin
            st_nxt    = DRIVE;
            accel_nxt = drive_accel;
          end else begin
            accel_nxt = 4'd0;
          end
          brake_nxt = brake_raw;
        end
        default: begin
          st_nxt    = FAULT;
          accel_nxt = 4'd0;
          brake_nxt = 4'hF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st        <= IDLE;
      cnt       <= 16'd0;
      fcnt      <= 4'd0;
      accel_out <= 4'd0;
      brake_out <= 4'd0;
      cmd_valid <= 1'b0;
      override  <= 1'b0;
      fault     <= 1'b0;
`ifdef PEDAL_AVG_EN
      hist0     <= 4'd0;
      hist1     <= 4'd0;
      hist2     <= 4'd0;
`endif
    end else if (!ena) begin
      cmd_valid <= 1'b0;
    end else if (tick) begin
      cnt       <= 16'd0;
      st        <= st_nxt;
      fcnt      <= fcnt_nxt;
      accel_out <= accel_nxt;
      brake_out <= brake_nxt;
      cmd_valid <= 1'b1;
      override  <= (st_nxt == OVERRIDE);
      fault     <= (st_nxt == FAULT);
`ifdef PEDAL_AVG_EN
      hist0     <= accel_raw;
      hist1     <= hist0;
      hist2     <= hist1;
`endif
    end else begin
      cnt       <= cnt + 16'd1;
      cmd_valid <= 1'b0;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_ev_pedal_conditioner.sv
// Directed bench for ev_pedal_conditioner with SAMPLE_DIV=4, RAMP_STEP=1, FAULT_LIMIT=3.
module tb_ev_pedal_conditioner;

  logic       clk = 1'b0;
  logic       rst, ena, power_on;
  logic [3:0] accel_raw, brake_raw;
  logic [3:0] accel_out, brake_out;
  logic       cmd_valid, override, fault;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  ev_pedal_conditioner #(.SAMPLE_DIV(4), .RAMP_STEP(1), .FAULT_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .power_on(power_on),
    .accel_raw(accel_raw), .brake_raw(brake_raw),
    .accel_out(accel_out), .brake_out(brake_out), .cmd_valid(cmd_valid),
    .state(state), .override(override), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic wait_update(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_valid && n < 50);
    if (!cmd_valid) begin
      tests++; fails++;
      $display("FAIL update_timeout: no cmd_valid within %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; power_on = 1'b0; accel_raw = 4'd5; brake_raw = 4'd5;
    repeat (2) @(negedge clk);
    tests++;
    if ({accel_out, brake_out, cmd_valid, state, override, fault} !== 15'd0) begin
      fails++;
      $display("FAIL reset_outputs: got a=%0d b=%0d v=%0d s=%0d o=%0d f=%0d, want all 0",
               accel_out, brake_out, cmd_valid, state, override, fault);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if ({cmd_valid, state} !== 3'd0) begin
      fails++;
      $display("FAIL poweroff_idle: got v=%0d s=%0d, want 0 0", cmd_valid, state);
    end
  endtask

  task automatic test_ramp();
    int n;
    do_reset();
    power_on = 1'b1; accel_raw = 4'd8; brake_raw = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      wait_update(n);
      tests++;
      if (accel_out !== 4'(k) || state !== 2'd1 || n != 4) begin
        fails++;
        $display("FAIL ramp_step%0d: got a=%0d s=%0d gap=%0d, want a=%0d s=1 gap=4",
                 k, accel_out, state, n, k);
      end
    end
    wait_update(n);
    tests++;
    if (accel_out !== 4'd8) begin
      fails++;
      $display("FAIL ramp_hold: got a=%0d, want 8", accel_out);
    end
  endtask

  task automatic test_fast_release();
    int n;
    accel_raw = 4'd0;
    wait_update(n);
    tests++;
    if (accel_out !== 4'd0 || state !== 2'd1) begin
      fails++;
      $display("FAIL fast_release: got a=%0d s=%0d, want a=0 s=1", accel_out, state);
    end
  endtask

  task automatic test_override();
    int n;
    accel_raw = 4'd6; brake_raw = 4'd3;
    wait_update(n);
    tests++;
    if (accel_out !== 4'd0 || brake_out !== 4'd3 || override !== 1'b1 || state !== 2'd2) begin
      fails++;
      $display("FAIL override_enter: got a=%0d b=%0d o=%0d s=%0d, want 0 3 1 2",
               accel_out, brake_out, override, state);
    end
    brake_raw = 4'd0;
    wait_update(n);
    tests++;
    if (accel_out !== 4'd0 || brake_out !== 4'd0 || override !== 1'b1) begin
      fails++;
      $display("FAIL override_hold: got a=%0d b=%0d o=%0d, want 0 0 1", accel_out, brake_out, override);
    end
    accel_raw = 4'd0;
    wait_update(n);
    tests++;
    if (state !== 2'd1 || override !== 1'b0 || accel_out !== 4'd0) begin
      fails++;
      $display("FAIL override_exit: got s=%0d o=%0d a=%0d, want 1 0 0", state, override, accel_out);
    end
    accel_raw = 4'd6;
    for (int k = 1; k <= 3; k++) begin
      wait_update(n);
      tests++;
      if (accel_out !== 4'(k)) begin
        fails++;
        $display("FAIL override_reramp%0d: got a=%0d, want %0d", k, accel_out, k);
      end
    end
  endtask

  task automatic test_fault();
    int n;
    accel_raw = 4'hF; brake_raw = 4'hF;
    for (int k = 1; k <= 2; k++) begin
      wait_update(n);
      tests++;
      if (fault !== 1'b0) begin
        fails++;
        $display("FAIL fault_early%0d: got fault=%0d, want 0", k, fault);
      end
    end
    wait_update(n);
    tests++;
    if (fault !== 1'b1 || state !== 2'd3 || brake_out !== 4'hF || accel_out !== 4'd0 || override !== 1'b0) begin
      fails++;
      $display("FAIL fault_enter: got f=%0d s=%0d b=%0d a=%0d o=%0d, want 1 3 15 0 0",
               fault, state, brake_out, accel_out, override);
    end
    accel_raw = 4'd2; brake_raw = 4'd0;
    repeat (2) wait_update(n);
    tests++;
    if (fault !== 1'b1 || state !== 2'd3 || brake_out !== 4'hF || accel_out !== 4'd0) begin
      fails++;
      $display("FAIL fault_sticky: got f=%0d s=%0d b=%0d a=%0d, want 1 3 15 0",
               fault, state, brake_out, accel_out);
    end
    power_on = 1'b0;
    @(negedge clk);
    tests++;
    if (fault !== 1'b0 || state !== 2'd0 || brake_out !== 4'd0 || accel_out !== 4'd0) begin
      fails++;
      $display("FAIL fault_poweroff: got f=%0d s=%0d b=%0d a=%0d, want all 0",
               fault, state, brake_out, accel_out);
    end
  endtask

  task automatic test_reset_freeze();
    int n;
    do_reset();
    power_on = 1'b1; accel_raw = 4'd8; brake_raw = 4'd0;
    repeat (5) wait_update(n);
    tests++;
    if (accel_out !== 4'd5) begin
      fails++;
      $display("FAIL pre_reset_ramp: got a=%0d, want 5", accel_out);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({accel_out, brake_out, cmd_valid, state, override, fault} !== 15'd0) begin
      fails++;
      $display("FAIL midrun_reset: got a=%0d b=%0d v=%0d s=%0d, want all 0",
               accel_out, brake_out, cmd_valid, state);
    end
    wait_update(n);
    tests++;
    if (accel_out !== 4'd1 || n != 4) begin
      fails++;
      $display("FAIL reset_reramp: got a=%0d gap=%0d, want a=1 gap=4", accel_out, n);
    end
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (cmd_valid !== 1'b0 || accel_out !== 4'd1) begin
        fails++;
        $display("FAIL frozen%0d: got v=%0d a=%0d, want v=0 a=1", k, cmd_valid, accel_out);
      end
    end
    ena = 1'b1;
    wait_update(n);
    tests++;
    if (n + 3 != 7 || accel_out !== 4'd2) begin
      fails++;
      $display("FAIL freeze_delay: got gap=%0d a=%0d, want gap=7 a=2", n + 3, accel_out);
    end
  endtask

`ifdef PEDAL_AVG_EN
  task automatic test_averaging();
    int n;
    do_reset();
    power_on = 1'b1; accel_raw = 4'd8; brake_raw = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      wait_update(n);
      tests++;
      if (accel_out !== 4'(k)) begin
        fails++;
        $display("FAIL avg_step%0d: got a=%0d, want %0d", k, accel_out, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PEDAL_AVG_EN
    test_averaging();
`else
    test_ramp();
    test_fast_release();
    test_override();
    test_fault();
    test_reset_freeze();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
